mem_sched: RTL and testbench
============================

Name: mem_sched

Overview:
- Schedules the single pipelined backing memory between the instruction-fetch miss path and the data miss/store path.
- Arbitrates requests and allocates read tags (IDs).
- Routes memory responses back to the owning requester and tracks outstanding reads.
- Sits between the instruction/data memory engines and the memory model; replaces ad-hoc ack/ID muxing at top level.

Parameters:
PA_WIDTH, 32, physical address width
LINE_WIDTH, 128, cache line width in bits
ID_WIDTH, 2, tag width; max outstanding reads = 2**ID_WIDTH
STARVE_MAX, 4, consecutive lost arbitration cycles before instruction port gets priority (0 = instruction never promoted)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_instr_req  in  1  instruction read request, held until granted
i_instr_addr  in  PA_WIDTH  instruction line address
o_instr_gnt  out  1  instruction request accepted this cycle
o_instr_id  out  ID_WIDTH  tag assigned, valid with o_instr_gnt
i_data_req  in  1  data request, held until granted
i_data_write  in  1  1 = line write, 0 = line read
i_data_addr  in  PA_WIDTH  data line address
i_data_wdata  in  LINE_WIDTH  write line
o_data_gnt  out  1  data request accepted this cycle
o_data_id  out  ID_WIDTH  read tag, valid with o_data_gnt and !i_data_write
o_mem_enable  out  1  command valid to memory
o_mem_write  out  1  command is write
o_mem_addr  out  PA_WIDTH  command address
o_mem_data  out  LINE_WIDTH  write line
o_mem_id  out  ID_WIDTH  command tag (0 for writes)
i_mem_full  in  1  memory cannot accept a command this cycle
i_mem_resp_valid  in  1  read response valid
i_mem_resp_id  in  ID_WIDTH  response tag
i_mem_resp_data  in  LINE_WIDTH  response line
o_instr_resp_valid  out  1  response belongs to instruction port
o_data_resp_valid  out  1  response belongs to data port
o_resp_data  out  LINE_WIDTH  response line, passthrough
o_busy  out  1  at least one read outstanding
o_err  out  1  one-cycle pulse: response on non-outstanding tag

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Tag table valid bits, starvation counter and all o_mem_* registers cleared.
  - o_busy=0, o_err=0.
  - Responses arriving after reset for pre-reset tags are dropped and pulse o_err.
- Grant is combinational, at most one per cycle.
  - Eligible: request asserted, i_mem_full=0, and (write, or a free tag exists).
  - Writes are posted: no tag allocated, no response expected.
- Priority:
  - Data wins by default.
  - Instruction wins when the starvation counter equals STARVE_MAX and STARVE_MAX!=0.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, each cycle i_instr_req=1 while data is granted.
  - Clears on instruction grant or when i_instr_req=0.
- Tag allocation:
  - A read grant takes the lowest-index free tag.
  - Sets valid and owner (0=instr, 1=data) at the clock edge.
- Command issue: latency 1. The granted command appears on o_mem_* the cycle after grant with o_mem_enable=1; otherwise o_mem_enable=0 and the other o_mem_* outputs hold their previous values.
- Response routing is combinational from i_mem_resp_*:
  - o_instr_resp_valid = resp_valid & valid[id] & owner[id]==0.
  - o_data_resp_valid = resp_valid & valid[id] & owner[id]==1.
  - The tag is freed at the clock edge.
  - A freed tag is allocatable from the next cycle, never the same cycle.
- Response to an invalid tag: both resp_valid outputs 0, o_err=1 for one cycle, table unchanged.
- Simultaneous grant and response in one cycle: both processed independently.
- All tags busy: reads stall and writes still pass. i_mem_full=1: no grants.
- o_busy is registered: OR of all valid bits.

Optional Feature:
MEM_SCHED_PERF_EN
- Defined:
  - Adds outputs o_perf_instr_wait and o_perf_data_wait, each 32 bits.
  - Each counts cycles its port's request was asserted but not granted.
  - Both wrap at 2**32 and clear on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then idle: all outputs 0, o_busy=0, o_mem_enable=0 on the cycle after reset release.
- i_instr_req and i_data_req (read) asserted in the same cycle:
  - o_data_gnt=1, tag 0.
  - Next cycle o_mem_enable=1, o_mem_id=0.
  - Instruction granted tag 1 the following cycle.
- STARVE_MAX=4, data requests every cycle, instruction held:
  - Data granted 4 cycles.
  - 5th cycle o_instr_gnt=1.
  - Counter clears.
- ID_WIDTH=2, issue 4 data reads with no responses:
  - 5th read not granted; a data write is still granted with o_mem_id=0.
  - Response id=2 gives o_data_resp_valid=1; the next read gets tag 2 one cycle later.
- Response with id=3 when tag 3 free: o_err=1 one cycle, both resp_valid=0.
- i_mem_full=1 with both requests: no grant; grants resume the cycle i_mem_full falls.
- Assert rst with 2 reads outstanding, then respond: o_err pulses twice, o_busy=0.

Source files
------------

// File: rtl/mem_sched.sv
// mem_sched: arbitrates instruction/data line requests onto one pipelined memory,
// allocates read tags and routes tagged responses. Define MEM_SCHED_PERF_EN for wait counters.
module mem_sched #(
  parameter int unsigned PA_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_instr_req,
  input  logic [PA_WIDTH-1:0]   i_instr_addr,
  output logic                  o_instr_gnt,
  output logic [ID_WIDTH-1:0]   o_instr_id,
  input  logic                  i_data_req,
  input  logic                  i_data_write,
  input  logic [PA_WIDTH-1:0]   i_data_addr,
  input  logic [LINE_WIDTH-1:0] i_data_wdata,
  output logic                  o_data_gnt,
  output logic [ID_WIDTH-1:0]   o_data_id,
  output logic                  o_mem_enable,
  output logic                  o_mem_write,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic [LINE_WIDTH-1:0] o_mem_data,
  output logic [ID_WIDTH-1:0]   o_mem_id,
  input  logic                  i_mem_full,
  input  logic                  i_mem_resp_valid,
  input  logic [ID_WIDTH-1:0]   i_mem_resp_id,
  input  logic [LINE_WIDTH-1:0] i_mem_resp_data,
  output logic                  o_instr_resp_valid,
  output logic                  o_data_resp_valid,
  output logic [LINE_WIDTH-1:0] o_resp_data,
  output logic                  o_busy,
`ifdef MEM_SCHED_PERF_EN
  output logic [31:0]           o_perf_instr_wait,
  output logic [31:0]           o_perf_data_wait,
`endif
  output logic                  o_err
);

  localparam int unsigned NTAGS = 2 ** ID_WIDTH;
  localparam int unsigned SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [NTAGS-1:0]      valid_q, valid_d;
  logic [NTAGS-1:0]      owner_q, owner_d;   // 0 = instruction, 1 = data
  logic [SW-1:0]         starve_q, starve_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [PA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ID_WIDTH-1:0]   mem_id_q, mem_id_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  free_found;
  logic [ID_WIDTH-1:0]   free_id;
  logic                  instr_elig, data_elig, instr_prio;
  logic                  instr_gnt, data_gnt;
  logic                  resp_hit;

  // Lowest-index free tag; loop runs high to low so the last hit wins.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = int'(NTAGS) - 1; i >= 0; i--) begin
      if (!valid_q[ID_WIDTH'(i)]) begin
        free_found = 1'b1;
        free_id    = ID_WIDTH'(i);
      end
    end
  end

  // Single grant per cycle: data by default, instruction once starved long enough.
  always_comb begin
    instr_elig = i_instr_req & ~i_mem_full & free_found;
    data_elig  = i_data_req & ~i_mem_full & (i_data_write | free_found);
    instr_prio = (STARVE_MAX != 0) && (starve_q == SW'(STARVE_MAX));
    instr_gnt  = instr_elig & (instr_prio | ~data_elig);
    data_gnt   = data_elig & ~instr_gnt;
  end

  assign resp_hit           = i_mem_resp_valid & valid_q[i_mem_resp_id];
  assign o_instr_resp_valid = resp_hit & ~owner_q[i_mem_resp_id];
  assign o_data_resp_valid  = resp_hit & owner_q[i_mem_resp_id];
  assign o_resp_data        = i_mem_resp_data;

  assign o_instr_gnt = instr_gnt;
  assign o_instr_id  = free_id;
  assign o_data_gnt  = data_gnt;
  assign o_data_id   = free_id;

  always_comb begin
    valid_d      = valid_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    mem_enable_d = 1'b0;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_id_d     = mem_id_q;
    err_d        = 1'b0;

    // Response frees its tag; allocation below only touches free tags, so no overlap.
    if (i_mem_resp_valid) begin
      if (valid_q[i_mem_resp_id]) valid_d[i_mem_resp_id] = 1'b0;
      else                        err_d = 1'b1;
    end

    if (instr_gnt) begin
      valid_d[free_id] = 1'b1;
      owner_d[free_id] = 1'b0;
      mem_enable_d     = 1'b1;
      mem_write_d      = 1'b0;
      mem_addr_d       = i_instr_addr;
      mem_id_d         = free_id;
    end else if (data_gnt) begin
      mem_enable_d = 1'b1;
      mem_write_d  = i_data_write;
      mem_addr_d   = i_data_addr;
      mem_data_d   = i_data_wdata;
      if (i_data_write) begin
        mem_id_d = '0;
      end else begin
        valid_d[free_id] = 1'b1;
        owner_d[free_id] = 1'b1;
        mem_id_d         = free_id;
      end
    end

    if (!i_instr_req || instr_gnt) starve_d = '0;
    else if (data_gnt && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);

    busy_d = |valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      owner_q      <= '0;
      starve_q     <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_id_q     <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_id_q     <= mem_id_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign o_mem_enable = mem_enable_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_mem_id     = mem_id_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

`ifdef MEM_SCHED_PERF_EN
  logic [31:0] perf_instr_q, perf_instr_d;
  logic [31:0] perf_data_q, perf_data_d;

  // Cycles a request sat waiting; wraps naturally at 2**32.
  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_data_d  = perf_data_q;
    if (i_instr_req && !instr_gnt) perf_instr_d = perf_instr_q + 32'd1;
    if (i_data_req && !data_gnt)   perf_data_d  = perf_data_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_data_q  <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_data_q  <= perf_data_d;
    end
  end

  assign o_perf_instr_wait = perf_instr_q;
  assign o_perf_data_wait  = perf_data_q;
`endif

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: cycle-by-cycle vector bench for mem_sched with default parameters.
module tb_mem_sched;

  localparam int unsigned PA_W   = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned ID_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_instr_req;
  logic [PA_W-1:0]   i_instr_addr;
  logic              o_instr_gnt;
  logic [ID_W-1:0]   o_instr_id;
  logic              i_data_req;
  logic              i_data_write;
  logic [PA_W-1:0]   i_data_addr;
  logic [LINE_W-1:0] i_data_wdata;
  logic              o_data_gnt;
  logic [ID_W-1:0]   o_data_id;
  logic              o_mem_enable;
  logic              o_mem_write;
  logic [PA_W-1:0]   o_mem_addr;
  logic [LINE_W-1:0] o_mem_data;
  logic [ID_W-1:0]   o_mem_id;
  logic              i_mem_full;
  logic              i_mem_resp_valid;
  logic [ID_W-1:0]   i_mem_resp_id;
  logic [LINE_W-1:0] i_mem_resp_data;
  logic              o_instr_resp_valid;
  logic              o_data_resp_valid;
  logic [LINE_W-1:0] o_resp_data;
  logic              o_busy;
  logic              o_err;
`ifdef MEM_SCHED_PERF_EN
  logic [31:0]       o_perf_instr_wait;
  logic [31:0]       o_perf_data_wait;
`endif

  always #5 clk = ~clk;

  mem_sched #(
    .PA_WIDTH(PA_W), .LINE_WIDTH(LINE_W), .ID_WIDTH(ID_W), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
    .o_instr_gnt(o_instr_gnt), .o_instr_id(o_instr_id),
    .i_data_req(i_data_req), .i_data_write(i_data_write),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .o_data_gnt(o_data_gnt), .o_data_id(o_data_id),
    .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_id(o_mem_id),
    .i_mem_full(i_mem_full), .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_id(i_mem_resp_id), .i_mem_resp_data(i_mem_resp_data),
    .o_instr_resp_valid(o_instr_resp_valid), .o_data_resp_valid(o_data_resp_valid),
    .o_resp_data(o_resp_data), .o_busy(o_busy),
`ifdef MEM_SCHED_PERF_EN
    .o_perf_instr_wait(o_perf_instr_wait), .o_perf_data_wait(o_perf_data_wait),
`endif
    .o_err(o_err)
  );

  typedef struct {
    logic rst, ireq, dreq, dwr, full, rv;
    logic [ID_W-1:0] rid;
    logic e_ignt; logic [ID_W-1:0] e_iid;
    logic e_dgnt; logic [ID_W-1:0] e_did;
    logic e_men, e_mwr; logic [ID_W-1:0] e_mid;
    logic e_irv, e_drv, e_busy, e_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int sidx  = 0;
  logic [PA_W-1:0]   m_addr = '0;
  logic [LINE_W-1:0] m_data = '0;
  vec_t tbl[31];

  function automatic vec_t mk(input int r, input int ir, input int dr, input int dw,
                              input int fu, input int rv, input int rid,
                              input int ig, input int iid, input int dg, input int did,
                              input int me, input int mw, input int mid,
                              input int irv, input int drv, input int bz, input int er);
    vec_t v;
    v.rst = 1'(r); v.ireq = 1'(ir); v.dreq = 1'(dr); v.dwr = 1'(dw); v.full = 1'(fu);
    v.rv = 1'(rv); v.rid = ID_W'(rid);
    v.e_ignt = 1'(ig); v.e_iid = ID_W'(iid); v.e_dgnt = 1'(dg); v.e_did = ID_W'(did);
    v.e_men = 1'(me); v.e_mwr = 1'(mw); v.e_mid = ID_W'(mid);
    v.e_irv = 1'(irv); v.e_drv = 1'(drv); v.e_busy = 1'(bz); v.e_err = 1'(er);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, sidx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, then advance past the rising edge.
  task automatic step(input vec_t v);
    logic [PA_W-1:0]   ia, da;
    logic [LINE_W-1:0] wd, rd;
    ia = 32'h1000_0000 | PA_W'(sidx);
    da = 32'h2000_0000 | PA_W'(sidx);
    wd = {4{32'hD000_0000 | 32'(sidx)}};
    rd = {4{32'hAAAA_0000 | 32'(sidx)}};
    rst = v.rst; i_instr_req = v.ireq; i_instr_addr = ia;
    i_data_req = v.dreq; i_data_write = v.dwr; i_data_addr = da; i_data_wdata = wd;
    i_mem_full = v.full; i_mem_resp_valid = v.rv; i_mem_resp_id = v.rid; i_mem_resp_data = rd;
    @(negedge clk);
    chk("instr_gnt", LINE_W'(o_instr_gnt), LINE_W'(v.e_ignt));
    chk("data_gnt", LINE_W'(o_data_gnt), LINE_W'(v.e_dgnt));
    if (v.e_ignt) chk("instr_id", LINE_W'(o_instr_id), LINE_W'(v.e_iid));
    if (v.e_dgnt && !v.dwr) chk("data_id", LINE_W'(o_data_id), LINE_W'(v.e_did));
    chk("mem_enable", LINE_W'(o_mem_enable), LINE_W'(v.e_men));
    if (v.e_men) begin
      chk("mem_write", LINE_W'(o_mem_write), LINE_W'(v.e_mwr));
      chk("mem_id", LINE_W'(o_mem_id), LINE_W'(v.e_mid));
      chk("mem_addr", LINE_W'(o_mem_addr), LINE_W'(m_addr));
      if (v.e_mwr) chk("mem_data", o_mem_data, m_data);
    end
    chk("instr_resp_valid", LINE_W'(o_instr_resp_valid), LINE_W'(v.e_irv));
    chk("data_resp_valid", LINE_W'(o_data_resp_valid), LINE_W'(v.e_drv));
    if (v.rv) chk("resp_data", o_resp_data, rd);
    chk("busy", LINE_W'(o_busy), LINE_W'(v.e_busy));
    chk("err", LINE_W'(o_err), LINE_W'(v.e_err));
    if (v.e_ignt) m_addr = ia;
    else if (v.e_dgnt) begin
      m_addr = da;
      m_data = wd;
    end
    @(posedge clk);
    #1;
    sidx++;
  endtask

  initial begin
    int ireq_pat[10];
    rst = 1'b1; i_instr_req = 1'b0; i_instr_addr = '0; i_data_req = 1'b0;
    i_data_write = 1'b0; i_data_addr = '0; i_data_wdata = '0; i_mem_full = 1'b0;
    i_mem_resp_valid = 1'b0; i_mem_resp_id = '0; i_mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;

    //              r ir dr dw fu rv id ig iid dg did me mw mid irv drv bz er
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 2, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0);
    tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[20] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[21] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[22] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0);
    tbl[23] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 0);
    tbl[24] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[25] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[27] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[29] = mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) step(tbl[i]);

    // Starvation: data writes every cycle; the ireq gap at cycle 3 restarts the count.
    ireq_pat = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    for (int c = 0; c < 10; c++) begin
      step(mk(0, ireq_pat[c], 1, 1, 0, 0, 0,
              (c == 8) ? 1 : 0, 0, (c == 8) ? 0 : 1, 0,
              (c == 0) ? 0 : 1, (c == 9) ? 0 : 1, 0,
              0, 0, (c == 9) ? 1 : 0, 0));
    end
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0));

    // Reset with two reads outstanding; both late responses are errors.
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
